// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// driving ALU selects, memory requests and PC/register-file write enables.
module rv32i_mc_ctrl #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        less,
    input  logic        zero,
    output logic [3:0]  ALUctr,
    output logic        ALUAsrc,
    output logic [1:0]  ALUBsrc,
    output logic [2:0]  ExtOp,
    output logic        IRWr,
    output logic        ALUOutWr,
    output logic        PCWr,
    output logic [1:0]  PCSrc,
    output logic        RegWr,
    output logic [1:0]  WBSel,
    output logic        MemRd,
    output logic        MemWr,
    output logic [2:0]  MemOp,
    output logic        illegal,
    output logic [2:0]  state
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] TRAP   = 3'd5;

    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_U = 3'd1;
    localparam logic [2:0] EXT_S = 3'd2;
    localparam logic [2:0] EXT_B = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_op, is_opimm, is_lui, is_auipc;
    logic       is_load, is_store, is_jal, is_jalr, is_branch;
    logic       f7_ok, bad, alt, taken;
    logic [3:0] alu_rr, alu_br;
    logic [2:0] next_state;
    logic       unused;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign MemOp  = funct3;
    assign unused = ^{instr[24:15], instr[11:7]};

    assign is_op     = opcode == 7'b0110011;
    assign is_opimm  = opcode == 7'b0010011;
    assign is_lui    = opcode == 7'b0110111;
    assign is_auipc  = opcode == 7'b0010111;
    assign is_load   = opcode == 7'b0000011;
    assign is_store  = opcode == 7'b0100011;
    assign is_jal    = opcode == 7'b1101111;
    assign is_jalr   = opcode == 7'b1100111;
    assign is_branch = opcode == 7'b1100011;

    assign f7_ok = (funct7 == 7'h00) ||
                   (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    assign bad = !(is_op | is_opimm | is_lui | is_auipc | is_load |
                   is_store | is_jal | is_jalr | is_branch) ||
                 (is_op && !f7_ok);

    // funct7[5] selects sub only on register ops, sra on either form
    assign alt    = funct7[5] &&
                    (funct3 == 3'b101 || (is_op && funct3 == 3'b000));
    assign alu_rr = (funct3 == 3'b011) ? 4'b1010 : {alt, funct3};
    assign alu_br = (funct3[2:1] == 2'b11) ? 4'b1010 : 4'b0010;
    assign taken  = (funct3[2] ? less : zero) ^ funct3[0];

    always_comb begin
        next_state = state;
        ALUctr     = 4'b0000;
        ALUAsrc    = 1'b0;
        ALUBsrc    = 2'b00;
        ExtOp      = EXT_I;
        IRWr       = 1'b0;
        ALUOutWr   = 1'b0;
        PCWr       = 1'b0;
        PCSrc      = 2'b00;
        RegWr      = 1'b0;
        WBSel      = 2'b00;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        unique case (state)
            FETCH: begin
                IRWr       = imem_ready;
                next_state = imem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUAsrc    = 1'b1;
                ALUBsrc    = 2'b01;
                ExtOp      = EXT_B;
                ALUOutWr   = 1'b1;
                next_state = bad ? TRAP : EXEC;
            end
            EXEC: begin
                ALUOutWr   = !is_branch;
                next_state = (is_load || is_store) ? MEM : WB;
                unique case (1'b1)
                    is_op:    ALUctr = alu_rr;
                    is_opimm: begin
                        ALUctr  = alu_rr;
                        ALUBsrc = 2'b01;
                    end
                    is_lui: begin
                        ALUctr  = 4'b0011;
                        ALUBsrc = 2'b01;
                        ExtOp   = EXT_U;
                    end
                    is_auipc: begin
                        ALUAsrc = 1'b1;
                        ALUBsrc = 2'b01;
                        ExtOp   = EXT_U;
                    end
                    is_load:  ALUBsrc = 2'b01;
                    is_store: begin
                        ALUBsrc = 2'b01;
                        ExtOp   = EXT_S;
                    end
                    is_jal: begin
                        ALUAsrc = 1'b1;
                        ALUBsrc = 2'b01;
                        ExtOp   = EXT_J;
                    end
                    is_jalr:  ALUBsrc = 2'b01;
                    is_branch: begin
                        ALUctr     = alu_br;
                        ExtOp      = EXT_B;
                        PCWr       = 1'b1;
                        PCSrc      = taken ? 2'b01 : 2'b00;
                        next_state = FETCH;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                MemRd = is_load;
                MemWr = is_store;
                if (dmem_ready) begin
                    if (is_load) begin
                        next_state = WB;
                    end else begin
                        PCWr       = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            WB: begin
                RegWr      = 1'b1;
                PCWr       = 1'b1;
                WBSel      = is_load ? 2'b01 :
                             (is_jal || is_jalr) ? 2'b10 : 2'b00;
                PCSrc      = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
                next_state = FETCH;
            end
            TRAP:    next_state = TRAP;
            default: next_state = FETCH;
        endcase
        // nothing may be written in the cycle reset is sampled
        if (reset) begin
            next_state = RESET_STATE;
            IRWr       = 1'b0;
            ALUOutWr   = 1'b0;
            PCWr       = 1'b0;
            RegWr      = 1'b0;
            MemRd      = 1'b0;
            MemWr      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RESET_STATE;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE && bad)
                illegal <= 1'b1;
        end
    end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
- Multi-cycle RV32I control unit: decodes the fetched instruction, sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath.
- Produces the 4-bit ALUctr and operand selects that drive the ALU.
- Consumes the ALU's less/zero flags to resolve branches.
- Sits between instruction/data memory handshakes and the register file / PC / ALU datapath.

Parameters:
- RESET_STATE, 3'd0, state encoding entered on reset (FETCH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction word from the instruction register. Valid from DECODE onward.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- less  in  1  ALU less flag.
- zero  in  1  ALU zero flag. Equality result when ALUctr[2:0]=010.
- ALUctr  out  4  ALU operation.
- ALUAsrc  out  1  0=rs1, 1=PC.
- ALUBsrc  out  2  00=rs2, 01=imm, 10=const 4.
- ExtOp  out  3  immediate format: 000 I, 001 U, 010 S, 011 B, 100 J.
- IRWr  out  1  load instruction register.
- ALUOutWr  out  1  latch ALU result into ALUout register.
- PCWr  out  1  write PC.
- PCSrc  out  2  00=PC+4, 01=ALUout, 10={ALUout[31:1],1'b0}.
- RegWr  out  1  register-file write.
- WBSel  out  2  00=ALUout, 01=load data, 10=PC+4.
- MemRd  out  1  data read request.
- MemWr  out  1  data write request.
- MemOp  out  3  funct3 passthrough for size/sign.
- illegal  out  1  sticky illegal-instruction flag.
- state  out  3  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset: state=FETCH. All write enables and requests (IRWr, ALUOutWr, PCWr, RegWr, MemRd, MemWr) are 0. illegal=0.
- Reset asserted in any state, including mid-MEM: the next state is FETCH. No write enable is asserted in the reset cycle.
- Outputs are combinational from the state register and instr. The state register is the only sequential element besides illegal.
- FETCH:
  - IRWr = imem_ready.
  - Stay in FETCH while imem_ready=0. Go to DECODE when imem_ready=1.
- DECODE:
  - ALUAsrc=1, ALUBsrc=01, ExtOp=B, ALUctr=0000, ALUOutWr=1. This precomputes the branch target.
  - Unsupported opcode, or OP with an invalid funct7: go to TRAP. Otherwise go to EXEC.
- EXEC, per opcode:
  - OP: A=rs1, B=rs2, ALUOutWr=1, then WB.
  - OP-IMM: A=rs1, B=imm(I), ALUOutWr=1, then WB.
  - LUI: ALUctr=0011 (B pass-through), imm(U), ALUOutWr=1, then WB.
  - AUIPC: A=PC, B=imm(U), add, ALUOutWr=1, then WB.
  - LOAD/STORE: A=rs1, B=imm(I or S), add, ALUOutWr=1, then MEM.
  - JAL: A=PC, B=imm(J), add, ALUOutWr=1, then WB.
  - JALR: A=rs1, B=imm(I), add, ALUOutWr=1, then WB.
  - BRANCH: A=rs1, B=rs2, ALUOutWr=0. PCWr=1 always, then FETCH.
    - PCSrc=01 if taken, else 00.
    - BEQ/BNE: ALUctr=0010, taken on zero / !zero.
    - BLT/BGE: ALUctr=0010, taken on less / !less.
    - BLTU/BGEU: ALUctr=1010, taken on less / !less.
- ALUctr mapping for OP / OP-IMM, by funct3 and funct7[5]:
  - add 0000; sub 1000 (OP only).
  - sll 0001; slt 0010; sltu 1010.
  - xor 0100; srl 0101; sra 1101.
  - or 0110; and 0111.
  - OP-IMM never yields sub. funct7[5] applies to shifts only.
- MEM:
  - LOAD: MemRd=1. Go to WB when dmem_ready=1.
  - STORE: MemWr=1. When dmem_ready=1: PCWr=1, PCSrc=00, go to FETCH.
  - Requests are held steady while waiting for dmem_ready.
- WB:
  - RegWr=1 and PCWr=1.
  - WBSel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - PCSrc: 01 for JAL, 10 for JALR, else 00.
  - Next state FETCH.
- TRAP: illegal=1. All enables 0. Remains in TRAP until reset.
- Latency in cycles, with zero memory wait:
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - Load: 5. Store: 4. Branch: 3.
  - Each memory wait cycle adds 1.
- Exactly one PCWr pulse per retired instruction. RegWr is never asserted outside WB.

Test Plan:
- Reset mid-MEM of a load with dmem_ready=0 -> next cycle state=0, MemRd=0, RegWr=0, PCWr=0.
- add x3,x1,x2 (0x002081B3), imem_ready=1 -> states 0,1,2,4. EXEC ALUctr=0000. WB RegWr=1, WBSel=00, PCSrc=00. Total 4 cycles.
- sra x3,x1,x2 (0x4020D1B3) -> EXEC ALUctr=1101. srai (0x4030D193) -> ALUctr=1101, ALUBsrc=01.
- bltu x1,x2,+8 (0x0020E463): EXEC ALUctr=1010.
  - less=1 -> PCWr=1, PCSrc=01.
  - less=0 -> PCWr=1, PCSrc=00.
  - Either case: next state FETCH, 3 cycles total.
- lw x5,4(x1) (0x0040A283) with dmem_ready=0 for 2 cycles -> MEM held 3 cycles with MemRd=1. Then WB with WBSel=01. 7 cycles total.
- Instruction 0xFFFFFFFF -> DECODE then TRAP. illegal=1 and all enables 0 for 10+ cycles, until reset returns state=0 and illegal=0.
